// File: rtl/i2c_eeprom_seq_if.sv
// Command/response channel between the EEPROM sequencer and the byte-level
// I2C master engine.
//   cmd_valid/cmd_ready : command handshake, payload cmd_op/cmd_wdata
//   cmd_op              : 0=START 1=WRITE 2=READ_ACK 3=READ_NACK 4=STOP
//   rsp_valid           : 1-cycle pulse when the engine finishes a command
//   rsp_rdata           : received byte (READ_*)
//   rsp_nack            : slave NACKed a WRITE, qualified by rsp_valid
// master = sequencer side, slave = engine side.
interface i2c_eeprom_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
  );
endinterface

// File: rtl/i2c_eeprom_seq.sv
// SFR-mapped 24xx EEPROM transaction sequencer. The CPU programs device,
// word address, length and up to BUF_DEPTH data bytes, then sets GO; the
// block walks START / address bytes / data / STOP through the byte engine.
// Ports:
//   clk, rst_in_n         : clock, synchronous active-low reset
//   sfr_addr/sfr_data_out : SFR address and write data from the core
//   sfr_wr/sfr_rd         : SFR write / read strobes
//   sfr_data_in           : register read data, 0 when not addressed
//   eng                   : command/response channel to the byte engine
//   irq                   : IE & (DONE | NACK)
// Register map (offset from SFR_BASE):
//   0 CTRL [0] GO [1] RW [3:2] LEN-1 [7] IE
//   1 DEV  2 ADDRH  3 ADDRL  4 DATA (buffer port)  5 STAT [0] BUSY [1] DONE [2] NACK
//
// state | meaning (each state issues one command, then waits for its response)
// IDLE  | no transaction; leaves one cycle after GO sets BUSY
// S1    | START
// DW    | WRITE {DEV,0}
// AH    | WRITE ADDRH
// AL    | WRITE ADDRL
// WD    | WRITE buf[cnt], LEN times
// RS    | repeated START
// DR    | WRITE {DEV,1}
// RD    | READ_ACK, READ_NACK on the last byte; store to buf[cnt]
// SP    | STOP; its response ends the transaction
module i2c_eeprom_seq #(
  parameter logic [7:0] SFR_BASE  = 8'hA1,
  parameter int         BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_in_n,
  input  logic [7:0]       sfr_addr,
  input  logic [7:0]       sfr_data_out,
  input  logic             sfr_wr,
  input  logic             sfr_rd,
  output logic [7:0]       sfr_data_in,
  i2c_eeprom_seq_if.master eng,
  output logic             irq
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S1, ST_DW, ST_AH, ST_AL, ST_WD, ST_RS, ST_DR, ST_RD, ST_SP
  } state_t;

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_READ_ACK  = 3'd2;
  localparam logic [2:0] OP_READ_NACK = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;

  state_t     state, state_nxt;
  logic       waiting, waiting_nxt;

  logic [6:0] dev;
  logic [7:0] addr_h, addr_l;
  logic       rw, ie;
  logic [1:0] len_m1;
  logic       busy, done, nack;
  logic       aborted;
  logic [1:0] wptr, rptr, cnt;
  logic [7:0] buf_q [BUF_DEPTH];
  logic       rd_data_q;

  logic [7:0] offs;
  logic       wr_ctrl, wr_dev, wr_addr_h, wr_addr_l, wr_data, wr_stat;
  logic       go, rd_data_now, rd_data_rise;

  logic       issue, fire, take, got_nack, last_byte, is_write;
  logic [2:0] op_sel;
  logic [7:0] wdata_sel;

  // Out-of-range addresses wrap to large offsets and never hit.
  assign offs         = sfr_addr - SFR_BASE;
  assign wr_ctrl      = sfr_wr && (offs == 8'd0);
  assign wr_dev       = sfr_wr && (offs == 8'd1);
  assign wr_addr_h    = sfr_wr && (offs == 8'd2);
  assign wr_addr_l    = sfr_wr && (offs == 8'd3);
  assign wr_data      = sfr_wr && (offs == 8'd4);
  assign wr_stat      = sfr_wr && (offs == 8'd5);
  assign go           = wr_ctrl && sfr_data_out[0] && !busy;
  assign rd_data_now  = sfr_rd && (offs == 8'd4);
  // A DATA read held for several cycles advances the read pointer once.
  assign rd_data_rise = rd_data_now && !rd_data_q;

  assign last_byte = (cnt == len_m1);
  assign issue     = (state != ST_IDLE) && !waiting;
  assign fire      = issue && eng.cmd_ready;
  assign take      = waiting && eng.rsp_valid;
  assign got_nack  = take && is_write && eng.rsp_nack;

  always_comb begin
    op_sel    = OP_START;
    wdata_sel = 8'h00;
    is_write  = 1'b0;
    case (state)
      ST_DW: begin op_sel = OP_WRITE; wdata_sel = {dev, 1'b0};  is_write = 1'b1; end
      ST_AH: begin op_sel = OP_WRITE; wdata_sel = addr_h;       is_write = 1'b1; end
      ST_AL: begin op_sel = OP_WRITE; wdata_sel = addr_l;       is_write = 1'b1; end
      ST_WD: begin op_sel = OP_WRITE; wdata_sel = buf_q[cnt];   is_write = 1'b1; end
      ST_DR: begin op_sel = OP_WRITE; wdata_sel = {dev, 1'b1};  is_write = 1'b1; end
      ST_RD: op_sel = last_byte ? OP_READ_NACK : OP_READ_ACK;
      ST_SP: op_sel = OP_STOP;
      default: ;
    endcase
  end

  assign eng.cmd_valid = issue;
  assign eng.cmd_op    = issue ? op_sel : 3'd0;
  assign eng.cmd_wdata = issue ? wdata_sel : 8'h00;

  always_comb begin
    state_nxt   = state;
    waiting_nxt = waiting;
    if (state == ST_IDLE) begin
      waiting_nxt = 1'b0;
      if (busy) state_nxt = ST_S1;
    end else if (fire) begin
      waiting_nxt = 1'b1;
    end else if (take) begin
      waiting_nxt = 1'b0;
      case (state)
        ST_S1:   state_nxt = ST_DW;
        ST_DW:   state_nxt = eng.rsp_nack ? ST_SP : ST_AH;
        ST_AH:   state_nxt = eng.rsp_nack ? ST_SP : ST_AL;
        ST_AL:   state_nxt = eng.rsp_nack ? ST_SP : (rw ? ST_RS : ST_WD);
        ST_WD:   state_nxt = (eng.rsp_nack || last_byte) ? ST_SP : ST_WD;
        ST_RS:   state_nxt = ST_DR;
        ST_DR:   state_nxt = eng.rsp_nack ? ST_SP : ST_RD;
        ST_RD:   state_nxt = last_byte ? ST_SP : ST_RD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in_n) begin
      state   <= ST_IDLE;
      waiting <= 1'b0;
    end else begin
      state   <= state_nxt;
      waiting <= waiting_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in_n) begin
      dev       <= '0;
      addr_h    <= '0;
      addr_l    <= '0;
      rw        <= 1'b0;
      ie        <= 1'b0;
      len_m1    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      aborted   <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      rd_data_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      rd_data_q <= rd_data_now;
      if (rd_data_rise) rptr <= rptr + 2'd1;

      if (!busy) begin
        if (wr_ctrl) begin
          rw     <= sfr_data_out[1];
          len_m1 <= sfr_data_out[3:2];
          ie     <= sfr_data_out[7];
        end
        if (wr_dev)    dev    <= sfr_data_out[6:0];
        if (wr_addr_h) addr_h <= sfr_data_out;
        if (wr_addr_l) addr_l <= sfr_data_out;
        if (wr_data) begin
          buf_q[wptr] <= sfr_data_out;
          wptr        <= wptr + 2'd1;
        end
      end

      if (wr_stat) begin
        if (sfr_data_out[1]) done <= 1'b0;
        if (sfr_data_out[2]) nack <= 1'b0;
      end

      if (go) begin
        busy    <= 1'b1;
        done    <= 1'b0;
        nack    <= 1'b0;
        aborted <= 1'b0;
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
      end

      // Hardware status updates take priority over a same-cycle W1C.
      if (take) begin
        if (got_nack) begin
          nack    <= 1'b1;
          aborted <= 1'b1;
        end
        if ((state == ST_WD && !eng.rsp_nack) || state == ST_RD) cnt <= cnt + 2'd1;
        if (state == ST_RD) buf_q[cnt] <= eng.rsp_rdata;
        if (state == ST_SP) begin
          busy <= 1'b0;
          // aborted survives a CPU W1C of NACK mid-transaction.
          done <= !aborted;
        end
      end
    end
  end

  always_comb begin
    sfr_data_in = 8'h00;
    if (sfr_rd) begin
      case (offs)
        8'd0:    sfr_data_in = {ie, 3'b000, len_m1, rw, 1'b0};
        8'd1:    sfr_data_in = {1'b0, dev};
        8'd2:    sfr_data_in = addr_h;
        8'd3:    sfr_data_in = addr_l;
        8'd4:    sfr_data_in = buf_q[rptr];
        8'd5:    sfr_data_in = {5'b00000, nack, done, busy};
        default: sfr_data_in = 8'h00;
      endcase
    end
  end

  assign irq = ie && (done || nack);

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
module tb_i2c_eeprom_seq;

  localparam logic [7:0] A_CTRL  = 8'hA1;
  localparam logic [7:0] A_DEV   = 8'hA2;
  localparam logic [7:0] A_ADDRH = 8'hA3;
  localparam logic [7:0] A_ADDRL = 8'hA4;
  localparam logic [7:0] A_DATA  = 8'hA5;
  localparam logic [7:0] A_STAT  = 8'hA6;

  localparam int E_START = 0;
  localparam int E_WR    = 256;
  localparam int E_RA    = 512;
  localparam int E_RN    = 768;
  localparam int E_STOP  = 1024;

  logic       clk = 1'b0;
  logic       rst_in_n = 1'b0;
  logic [7:0] sfr_addr = 8'h00;
  logic [7:0] sfr_data_out = 8'h00;
  logic       sfr_wr = 1'b0;
  logic       sfr_rd = 1'b0;
  logic [7:0] sfr_data_in;
  logic       irq;

  i2c_eeprom_seq_if eif ();

  i2c_eeprom_seq #(.SFR_BASE(8'hA1), .BUF_DEPTH(4)) dut (
    .clk          (clk),
    .rst_in_n     (rst_in_n),
    .sfr_addr     (sfr_addr),
    .sfr_data_out (sfr_data_out),
    .sfr_wr       (sfr_wr),
    .sfr_rd       (sfr_rd),
    .sfr_data_in  (sfr_data_in),
    .eng          (eif),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  // ---------------- engine model ----------------
  int         ops_q[$];
  int         acc_cyc[$];
  logic [7:0] eng_rd_q[$];
  int         eng_nack_idx = -1;
  int         eng_wr_cnt = 0;
  bit         eng_rand = 0;
  int         eng_delay = 0;
  int         hold_at = -1;
  int         hold_left = 0;
  int         stall_cycles = 0;
  int         stall_last = 0;
  bit         stall_bad = 0;
  logic [2:0] stall_op;
  logic [7:0] stall_wd;
  bit         pending = 0;
  int         rsp_wait = 0;
  logic [7:0] pend_rdata;
  logic       pend_nack;

  initial begin
    eif.cmd_ready = 1'b0;
    eif.rsp_valid = 1'b0;
    eif.rsp_rdata = 8'h00;
    eif.rsp_nack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      eif.rsp_valid = 1'b0;
      eif.rsp_nack  = 1'b0;
      eif.rsp_rdata = 8'h00;
      if (pending) begin
        if (rsp_wait == 0) begin
          eif.rsp_valid = 1'b1;
          eif.rsp_rdata = pend_rdata;
          eif.rsp_nack  = pend_nack;
          pending = 0;
        end else rsp_wait--;
      end
      if (hold_left > 0 && ops_q.size() == hold_at && eif.cmd_valid) begin
        eif.cmd_ready = 1'b0;
        if (stall_cycles == 0) begin
          stall_op = eif.cmd_op;
          stall_wd = eif.cmd_wdata;
        end else if (eif.cmd_op !== stall_op || eif.cmd_wdata !== stall_wd) stall_bad = 1;
        hold_left--;
        stall_cycles++;
        stall_last = cyc;
      end else begin
        eif.cmd_ready = eng_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (!rst_in_n) begin
        pending = 0;
      end else if (eif.cmd_valid && eif.cmd_ready) begin
        ops_q.push_back(int'(eif.cmd_op) * 256 + int'(eif.cmd_wdata));
        acc_cyc.push_back(cyc);
        pend_nack  = 1'b0;
        pend_rdata = 8'h00;
        if (eif.cmd_op == 3'd1) begin
          if (eng_wr_cnt == eng_nack_idx) pend_nack = 1'b1;
          eng_wr_cnt++;
        end
        if (eif.cmd_op == 3'd2 || eif.cmd_op == 3'd3)
          pend_rdata = (eng_rd_q.size() > 0) ? eng_rd_q.pop_front() : 8'($urandom);
        pending  = 1;
        rsp_wait = eng_rand ? $urandom_range(0, 2) : eng_delay;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sfr_addr = a; sfr_data_out = d; sfr_wr = 1'b1;
    @(posedge clk); #1;
    sfr_wr = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    sfr_addr = a; sfr_rd = 1'b1;
    @(negedge clk);
    d = sfr_data_in;
    @(posedge clk); #1;
    sfr_rd = 1'b0;
  endtask

  // ---------------- transaction model ----------------
  logic [6:0]  t_dev;
  logic [15:0] t_addr;
  int          t_len;
  bit          t_rw, t_ie;
  logic [31:0] t_d, t_rd;
  int          t_nack;
  int          exp_ops[$];

  // Expected engine command list from the 24xx protocol: full plan, cut
  // after the NACKed write and terminated with STOP.
  task automatic build_exp(output bit nacked);
    int plan[$];
    int wr_i;
    plan.push_back(E_START);
    plan.push_back(E_WR + {t_dev, 1'b0});
    plan.push_back(E_WR + t_addr[15:8]);
    plan.push_back(E_WR + t_addr[7:0]);
    if (!t_rw) begin
      for (int i = 0; i < t_len; i++) plan.push_back(E_WR + t_d[8*i +: 8]);
    end else begin
      plan.push_back(E_START);
      plan.push_back(E_WR + {t_dev, 1'b1});
      for (int i = 0; i < t_len; i++) plan.push_back((i == t_len - 1) ? E_RN : E_RA);
    end
    exp_ops.delete();
    nacked = 0;
    wr_i = 0;
    foreach (plan[k]) begin
      exp_ops.push_back(plan[k]);
      if (plan[k] >= E_WR && plan[k] < E_RA) begin
        if (wr_i == t_nack) begin nacked = 1; break; end
        wr_i++;
      end
    end
    exp_ops.push_back(E_STOP);
  endtask

  task automatic check_ops(input string tag);
    int bad = -1;
    nchk++;
    for (int i = 0; i < exp_ops.size(); i++)
      if (bad < 0 && (i >= ops_q.size() || ops_q[i] != exp_ops[i])) bad = i;
    if (bad < 0 && ops_q.size() != exp_ops.size()) bad = exp_ops.size();
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s ops: at index %0d got %0h (n=%0d) expected %0h (n=%0d)", tag, bad,
               (bad < ops_q.size()) ? ops_q[bad] : -1, ops_q.size(),
               (bad < exp_ops.size()) ? exp_ops[bad] : -1, exp_ops.size());
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 400; i++) begin
      sfr_read(A_STAT, v);
      if (!v[0]) return;
    end
    nchk++; nerr++;
    $display("FAIL %s busy_timeout: got busy expected idle", tag);
  endtask

  task automatic txn_start();
    sfr_write(A_DEV, {1'b0, t_dev});
    sfr_write(A_ADDRH, t_addr[15:8]);
    sfr_write(A_ADDRL, t_addr[7:0]);
    for (int i = 0; i < 4; i++) sfr_write(A_DATA, t_d[8*i +: 8]);
    ops_q.delete(); acc_cyc.delete(); eng_rd_q.delete();
    eng_wr_cnt = 0; eng_nack_idx = t_nack;
    for (int i = 0; i < t_len; i++) eng_rd_q.push_back(t_rd[8*i +: 8]);
    sfr_write(A_CTRL, {t_ie, 3'b000, 2'(t_len - 1), t_rw, 1'b1});
  endtask

  task automatic txn_finish(input string tag);
    bit nacked;
    logic [7:0] v;
    logic [7:0] eb [4];
    wait_idle(tag);
    build_exp(nacked);
    check_ops(tag);
    sfr_read(A_STAT, v);
    check({tag, " stat"}, v, nacked ? 8'h04 : 8'h02);
    check({tag, " irq"}, irq, t_ie);
    for (int i = 0; i < 4; i++) eb[i] = t_d[8*i +: 8];
    if (t_rw && !nacked) for (int i = 0; i < t_len; i++) eb[i] = t_rd[8*i +: 8];
    for (int i = 0; i < t_len; i++) begin
      sfr_read(A_DATA, v);
      check($sformatf("%s data%0d", tag, i), v, eb[i]);
    end
  endtask

  task automatic set_txn(input logic [6:0] dev, input logic [15:0] addr, input int len,
                         input bit rw, input bit ie, input logic [31:0] d,
                         input logic [31:0] rd, input int nk);
    t_dev = dev; t_addr = addr; t_len = len; t_rw = rw; t_ie = ie;
    t_d = d; t_rd = rd; t_nack = nk;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic       do_wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       do_rd;
    logic [7:0] raddr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    vecs.push_back('{1'b1, A_CTRL,  8'h8E, 1'b1, A_CTRL,  8'h8E});
    vecs.push_back('{1'b1, A_CTRL,  8'h70, 1'b1, A_CTRL,  8'h00});
    vecs.push_back('{1'b1, A_DEV,   8'hB5, 1'b1, A_DEV,   8'h35});
    vecs.push_back('{1'b1, A_ADDRH, 8'h12, 1'b1, A_ADDRH, 8'h12});
    vecs.push_back('{1'b1, A_ADDRL, 8'h34, 1'b1, A_ADDRL, 8'h34});
    vecs.push_back('{1'b1, A_STAT,  8'h07, 1'b1, A_STAT,  8'h00});
    vecs.push_back('{1'b1, 8'hA7,   8'h55, 1'b1, 8'hA7,   8'h00});
    vecs.push_back('{1'b1, 8'hA0,   8'h55, 1'b1, 8'hA0,   8'h00});
    vecs.push_back('{1'b0, 8'h00,   8'h00, 1'b0, A_DEV,   8'h00});
    vecs.push_back('{1'b0, 8'h00,   8'h00, 1'b1, A_ADDRH, 8'h12});

    repeat (3) @(posedge clk);
    #1 rst_in_n = 1'b1;
    @(negedge clk);
    check("rst cmd_valid", eif.cmd_valid, 1'b0);
    check("rst cmd_op", eif.cmd_op, 3'd0);
    check("rst cmd_wdata", eif.cmd_wdata, 8'h00);
    check("rst irq", irq, 1'b0);
    for (int a = 0; a < 6; a++) begin
      sfr_read(A_CTRL + 8'(a), v);
      check($sformatf("rst reg%0d", a), v, 8'h00);
    end

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) sfr_write(vecs[i].waddr, vecs[i].wdata);
      if (vecs[i].do_rd) sfr_read(vecs[i].raddr, v);
      else begin
        @(posedge clk); #1 sfr_addr = vecs[i].raddr;
        @(negedge clk); v = sfr_data_in;
      end
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // Single byte write, GO latency and zero-wait command spacing.
    set_txn(7'h50, 16'h0001, 1, 0, 1, 32'h000000A5, 32'h0, -1);
    txn_start();
    check("go lat c1", eif.cmd_valid, 1'b0);
    @(posedge clk); #1;
    check("go lat c2", eif.cmd_valid, 1'b1);
    txn_finish("wr1");
    begin
      int bad = 0;
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 2) bad++;
      check("cmd spacing", bad, 0);
    end
    sfr_write(A_STAT, 8'h02);
    check("w1c done irq", irq, 1'b0);
    sfr_read(A_STAT, v);
    check("w1c done stat", v, 8'h00);

    // Two byte read.
    set_txn(7'h50, 16'h1234, 2, 1, 1, 32'hDDCCBBAA, 32'h00002211, -1);
    txn_start();
    txn_finish("rd2");
    sfr_write(A_CTRL, 8'h00);
    check("ie clear irq", irq, 1'b0);

    // DATA read held for several cycles advances once.
    set_txn(7'h21, 16'h0F0F, 4, 0, 0, 32'h44332211, 32'h0, -1);
    txn_start();
    txn_finish("wr4");
    @(posedge clk); #1 sfr_addr = A_DATA; sfr_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1 sfr_rd = 1'b0;
    sfr_read(A_DATA, v);
    check("held rd advance", v, 8'h22);

    // NACK on the device byte.
    set_txn(7'h50, 16'h0001, 1, 0, 1, 32'h000000A5, 32'h0, 0);
    txn_start();
    txn_finish("nack dev");
    sfr_write(A_STAT, 8'h04);
    check("w1c nack irq", irq, 1'b0);

    // cmd_ready low for 10 cycles on the ADDRL command.
    hold_at = 3; hold_left = 10; stall_cycles = 0; stall_bad = 0;
    set_txn(7'h3C, 16'hBEEF, 2, 0, 0, 32'h00006655, 32'h0, -1);
    txn_start();
    txn_finish("stall");
    check("stall cycles", stall_cycles, 10);
    check("stall stable", stall_bad, 1'b0);
    check("stall accept", (acc_cyc.size() > 3) ? acc_cyc[3] - stall_last : -1, 1);
    hold_left = 0; hold_at = -1;

    // Writes while busy are ignored.
    eng_delay = 3;
    set_txn(7'h11, 16'h2233, 3, 0, 0, 32'h0ABBCC99, 32'h0, -1);
    txn_start();
    sfr_read(A_STAT, v);
    check("busy stat", v, 8'h01);
    sfr_write(A_CTRL, 8'h01);
    sfr_write(A_ADDRL, 8'hFF);
    sfr_write(A_DATA, 8'hEE);
    txn_finish("busy wr");

    // Reset pulse while the ADDRH command is outstanding.
    set_txn(7'h50, 16'h4567, 2, 0, 1, 32'h00008877, 32'h0, -1);
    txn_start();
    begin
      int n = 0;
      while (ops_q.size() < 3 && n < 200) begin @(posedge clk); n++; end
      check("reach AH", ops_q.size(), 3);
    end
    @(posedge clk); #1 rst_in_n = 1'b0;
    @(posedge clk); #1 rst_in_n = 1'b1;
    check("rst mid cmd_valid", eif.cmd_valid, 1'b0);
    sfr_read(A_STAT, v);
    check("rst mid stat", v, 8'h00);
    sfr_read(A_ADDRL, v);
    check("rst mid addrl", v, 8'h00);
    eng_delay = 0;
    set_txn(7'h50, 16'h4567, 2, 0, 1, 32'h00008877, 32'h0, -1);
    txn_start();
    txn_finish("after rst");

    // Randomized transactions with random ready/response timing.
    eng_rand = 1;
    for (int it = 0; it < 25; it++) begin
      set_txn(7'($urandom), 16'($urandom), $urandom_range(1, 4), 1'($urandom), 1'($urandom),
              $urandom, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1);
      txn_start();
      txn_finish($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
